// File: rtl/ahb_bridge_arbiter.sv
// Round-robin AHB-Lite arbiter and master mux in front of a single
// AHB-to-APB bridge slave port.
module ahb_bridge_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                       Hclk,
  input  logic                       Hresetn,
  input  logic [NUM_MASTERS-1:0]     Hbusreq,
  input  logic [NUM_MASTERS-1:0]     Hlock,
  input  logic [2*NUM_MASTERS-1:0]   Htrans_m,
  input  logic [NUM_MASTERS-1:0]     Hwrite_m,
  input  logic [32*NUM_MASTERS-1:0]  Haddr_m,
  input  logic [32*NUM_MASTERS-1:0]  Hwdata_m,
  input  logic                       Hready,
  output logic [NUM_MASTERS-1:0]     Hgrant,
  output logic [1:0]                 Hmaster,
  output logic                       Hmastlock,
  output logic [1:0]                 Htrans,
  output logic                       Hwrite,
  output logic [31:0]                Haddr,
  output logic [31:0]                Hwdata,
  output logic                       Hreadyin
);

  localparam logic [1:0] DEF = 2'(DEFAULT_MASTER);
  localparam logic [1:0] SEQ = 2'b11;

  logic [1:0] grant_idx;
  logic [1:0] data_master;
  logic [1:0] rr_last;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic       hold;

  // A locked requester or an in-flight SEQ beat pins the current owner.
  assign hold = (Hlock[grant_idx] & Hbusreq[grant_idx])
              | (Htrans_m[{Hmaster, 1'b0} +: 2] == SEQ);

  always_comb begin
    winner = DEF;
    found  = 1'b0;
    cand   = rr_last;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_last + 2'(k);
      if (!found && Hbusreq[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      grant_idx   <= DEF;
      rr_last     <= DEF;
      Hmaster     <= DEF;
      data_master <= DEF;
      Hmastlock   <= 1'b0;
    end else if (Hready) begin
      Hmaster     <= grant_idx;
      Hmastlock   <= Hlock[grant_idx];
      data_master <= Hmaster;
      if (!hold) begin
        grant_idx <= winner;
        if (found) rr_last <= winner;
      end
    end
  end

  assign Hgrant   = NUM_MASTERS'(1) << grant_idx;
  assign Htrans   = Htrans_m[{Hmaster, 1'b0} +: 2];
  assign Hwrite   = Hwrite_m[Hmaster];
  assign Haddr    = Haddr_m[{Hmaster, 5'b0} +: 32];
  assign Hwdata   = Hwdata_m[{data_master, 5'b0} +: 32];
  assign Hreadyin = Hready;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed bench for ahb_bridge_arbiter: ownership model checked every
// cycle plus literal expectations for each scenario.
module tb_ahb_bridge_arbiter;

  logic         Hclk = 1'b0;
  logic         Hresetn = 1'b1;
  logic [3:0]   Hbusreq = '0;
  logic [3:0]   Hlock = '0;
  logic [7:0]   Htrans_m = '0;
  logic [3:0]   Hwrite_m = '0;
  logic [127:0] Haddr_m = '0;
  logic [127:0] Hwdata_m = '0;
  logic         Hready = 1'b1;
  logic [3:0]   Hgrant;
  logic [1:0]   Hmaster;
  logic         Hmastlock;
  logic [1:0]   Htrans;
  logic         Hwrite;
  logic [31:0]  Haddr;
  logic [31:0]  Hwdata;
  logic         Hreadyin;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  ahb_bridge_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hbusreq(Hbusreq), .Hlock(Hlock),
    .Htrans_m(Htrans_m), .Hwrite_m(Hwrite_m), .Haddr_m(Haddr_m),
    .Hwdata_m(Hwdata_m), .Hready(Hready), .Hgrant(Hgrant),
    .Hmaster(Hmaster), .Hmastlock(Hmastlock), .Htrans(Htrans),
    .Hwrite(Hwrite), .Haddr(Haddr), .Hwdata(Hwdata), .Hreadyin(Hreadyin)
  );

  always #5 Hclk = ~Hclk;

  // Reference ownership state: who holds grant, address and data phase.
  int m_g  = 0;
  int m_hm = 0;
  int m_dm = 0;
  int m_rr = 0;
  bit m_ml = 0;

  always @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      m_g = 0; m_hm = 0; m_dm = 0; m_rr = 0; m_ml = 0;
    end else if (Hready) begin
      bit keep;
      bit got;
      int old_g;
      old_g = m_g;
      keep = (Hlock[old_g] && Hbusreq[old_g])
          || (((Htrans_m >> (2 * m_hm)) & 8'h3) == 8'h3);
      m_dm = m_hm;
      m_hm = old_g;
      m_ml = Hlock[old_g];
      if (!keep) begin
        got = 0;
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_rr + k) % 4;
          if (!got && Hbusreq[c]) begin
            m_g = c; m_rr = c; got = 1;
          end
        end
        if (!got) m_g = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Hclk) begin
    if (run) begin
      chk("m.Hgrant", 32'(Hgrant), 32'(4'b0001 << m_g));
      chk("m.Hmaster", 32'(Hmaster), 32'(m_hm));
      chk("m.Hmastlock", 32'(Hmastlock), 32'(m_ml));
      chk("m.Htrans", 32'(Htrans), 32'((Htrans_m >> (2 * m_hm)) & 8'h3));
      chk("m.Hwrite", 32'(Hwrite), 32'(Hwrite_m[m_hm]));
      chk("m.Haddr", Haddr, Haddr_m[32*m_hm +: 32]);
      chk("m.Hwdata", Hwdata, Hwdata_m[32*m_dm +: 32]);
      chk("m.Hreadyin", 32'(Hreadyin), 32'(Hready));
    end
  end

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic do_reset();
    Hbusreq = '0; Hlock = '0; Htrans_m = '0; Hready = 1'b1;
    Hresetn = 1'b0;
    step();
    Hresetn = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_g [4];
    logic [1:0] exp_m [4];
    exp_g = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
    exp_m = '{2'd0, 2'd1, 2'd2, 2'd1};
    for (int i = 0; i < 4; i++) begin
      Haddr_m[32*i +: 32]  = 32'h0000_1000 * (i + 1);
      Hwdata_m[32*i +: 32] = 32'hD000_0000 + i;
    end
    Hwrite_m = 4'b1010;
    #2;
    do_reset();
    run = 1'b1;

    // Idle for ten cycles: default master keeps everything.
    repeat (10) step();
    chk("idle.Hgrant", 32'(Hgrant), 32'h1);
    chk("idle.Hmaster", 32'(Hmaster), 32'h0);
    chk("idle.Hmastlock", 32'(Hmastlock), 32'h0);

    // Two competing masters alternate.
    Hbusreq = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr.Hgrant", 32'(Hgrant), 32'(exp_g[i]));
      chk("rr.Hmaster", 32'(Hmaster), 32'(exp_m[i]));
    end

    // SEQ burst on M2 blocks M1.
    do_reset();
    Hbusreq = 4'b0100;
    Htrans_m[5:4] = 2'b10;
    step();
    chk("burst.grant", 32'(Hgrant), 32'h4);
    step();
    chk("burst.own", 32'(Hmaster), 32'h2);
    Htrans_m[5:4] = 2'b11;
    Hbusreq = 4'b0110;
    repeat (3) begin
      step();
      chk("burst.hold", 32'(Hgrant), 32'h4);
    end
    Htrans_m[5:4] = 2'b00;
    Hbusreq = 4'b0010;
    step();
    chk("burst.release", 32'(Hgrant), 32'h2);

    // Locked M3 keeps the bus until Hlock drops.
    do_reset();
    Hbusreq = 4'b1001;
    Hlock = 4'b1000;
    step();
    chk("lock.grant", 32'(Hgrant), 32'h8);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("lock.hold", 32'(Hgrant), 32'h8);
      chk("lock.mastlock", 32'(Hmastlock), 32'h1);
    end
    Hlock = 4'b0000;
    step();
    chk("lock.release", 32'(Hgrant), 32'h1);

    // Hready low freezes a pending grant change.
    do_reset();
    Hbusreq = 4'b0010;
    Hready = 1'b0;
    repeat (3) begin
      step();
      chk("stall.grant", 32'(Hgrant), 32'h1);
      chk("stall.Haddr", Haddr, 32'h0000_1000);
    end
    Hready = 1'b1;
    step();
    chk("stall.go", 32'(Hgrant), 32'h2);
    step();
    chk("stall.Haddr2", Haddr, 32'h0000_2000);
    chk("stall.Hwdata", Hwdata, 32'hD000_0000);
    step();
    chk("stall.Hwdata2", Hwdata, 32'hD000_0001);

    // Asynchronous reset in the middle of a burst.
    Hbusreq = 4'b0100;
    Htrans_m = 8'b0011_0010;
    repeat (3) step();
    chk("mid.own", 32'(Hmaster), 32'h2);
    #2;
    Hresetn = 1'b0;
    #1;
    chk("arst.Hgrant", 32'(Hgrant), 32'h1);
    chk("arst.Hmaster", 32'(Hmaster), 32'h0);
    chk("arst.Htrans", 32'(Htrans), 32'h2);
    step();
    Hbusreq = '0;
    Htrans_m = '0;
    Hresetn = 1'b1;
    repeat (2) step();
    chk("recover.Hgrant", 32'(Hgrant), 32'h1);

    // Mixed traffic against the model.
    for (int i = 0; i < 300; i++) begin
      Hbusreq  = 4'($urandom);
      Hlock    = 4'($urandom) & 4'($urandom);
      Htrans_m = 8'($urandom);
      Hwrite_m = 4'($urandom);
      Hready   = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < 4; j++) begin
        Haddr_m[32*j +: 32]  = $urandom;
        Hwdata_m[32*j +: 32] = $urandom;
      end
      step();
    end

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
